// File: rtl/context_store.sv
// Per-context A/B/C/N state memory for the LOCO-I regular-mode path, with clear sweep and write-back forwarding.
// Optional feature macro: CTX_FWD_STATS_EN (adds fwd_count and init_busy outputs).
module context_store #(
    parameter int NUM_CTX = 365,
    parameter int CTX_W   = 9,
    parameter int A_INIT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    input  logic [CTX_W-1:0]  rd_ctx,
    output logic              rd_ready,
    output logic              q_valid,
    output logic [12:0]       A_Q,
    output logic signed [6:0] B_Q,
    output logic signed [7:0] C_Q,
    output logic [6:0]        N_Q,
    input  logic              wr_en,
    input  logic [CTX_W-1:0]  wr_ctx,
    input  logic [12:0]       A_Q_update,
    input  logic signed [6:0] B_Q_update,
    input  logic signed [7:0] C_Q_update,
    input  logic [6:0]        N_Q_update,
    output logic              init_done,
    output logic              ctx_err
`ifdef CTX_FWD_STATS_EN
    ,
    output logic [15:0]       fwd_count,
    output logic              init_busy
`endif
);

    localparam logic [CTX_W:0]   LP_NUM    = (CTX_W+1)'(NUM_CTX);
    localparam logic [CTX_W-1:0] LP_LAST   = CTX_W'(NUM_CTX - 1);
    localparam logic [34:0]      INIT_WORD = {13'(A_INIT), 7'd0, 8'd0, 7'd1};

    typedef enum logic {S_INIT, S_RUN} state_t;
    typedef enum logic [1:0] {SEL_ZERO, SEL_RAM, SEL_FWD, SEL_INIT} sel_t;

    state_t             r_state;
    sel_t               r_sel;
    logic [CTX_W-1:0]   r_cnt;
    logic               r_rd_ready;
    logic               r_q_valid;
    logic               r_init_done;
    logic               r_ctx_err;
    logic [34:0]        r_mem [NUM_CTX];
    logic [34:0]        r_rd_word;
    logic [34:0]        r_fwd_word;

    logic               w_rd_in;
    logic               w_wr_in;
    logic               w_rd_acc;
    logic               w_wr_run;
    logic               w_collide;
    logic               w_we;
    logic [CTX_W-1:0]   w_waddr;
    logic [CTX_W-1:0]   w_raddr;
    logic [34:0]        w_upd_word;
    logic [34:0]        w_wdata;
    logic [34:0]        w_q_word;

    assign w_rd_in    = {1'b0, rd_ctx} < LP_NUM;
    assign w_wr_in    = {1'b0, wr_ctx} < LP_NUM;
    assign w_rd_acc   = !rst && rd_valid && r_rd_ready;
    assign w_wr_run   = !rst && (r_state == S_RUN) && wr_en && w_wr_in;
    assign w_collide  = w_rd_acc && w_rd_in && w_wr_run && (wr_ctx == rd_ctx);
    assign w_upd_word = {A_Q_update, B_Q_update, C_Q_update, N_Q_update};

    // The clear sweep and the write-back share the single write port.
    assign w_we    = !rst && ((r_state == S_INIT) || w_wr_run);
    assign w_waddr = (r_state == S_INIT) ? r_cnt : wr_ctx;
    assign w_wdata = (r_state == S_INIT) ? INIT_WORD : w_upd_word;
    assign w_raddr = w_rd_in ? rd_ctx : '0;

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
        if (w_rd_acc)
            r_rd_word <= r_mem[w_raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_INIT;
            r_cnt       <= '0;
            r_rd_ready  <= 1'b0;
            r_q_valid   <= 1'b0;
            r_init_done <= 1'b0;
            r_ctx_err   <= 1'b0;
            r_sel       <= SEL_ZERO;
            r_fwd_word  <= '0;
        end else begin
            r_q_valid <= w_rd_acc;
            r_ctx_err <= (w_rd_acc && !w_rd_in) ||
                         ((r_state == S_RUN) && wr_en && !w_wr_in);
            case (r_state)
                S_INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LP_LAST) begin
                        r_state     <= S_RUN;
                        r_rd_ready  <= 1'b1;
                        r_init_done <= 1'b1;
                    end
                end
                S_RUN: ;
                default: r_state <= S_INIT;
            endcase
            // Selection is latched per accepted read so outputs hold until the next one.
            if (w_rd_acc) begin
                if (!w_rd_in)
                    r_sel <= SEL_INIT;
                else if (w_collide)
                    r_sel <= SEL_FWD;
                else
                    r_sel <= SEL_RAM;
                if (w_collide)
                    r_fwd_word <= w_upd_word;
            end
        end
    end

    always_comb begin
        w_q_word = '0;
        case (r_sel)
            SEL_ZERO: w_q_word = '0;
            SEL_RAM:  w_q_word = r_rd_word;
            SEL_FWD:  w_q_word = r_fwd_word;
            SEL_INIT: w_q_word = INIT_WORD;
            default:  w_q_word = '0;
        endcase
    end

    assign rd_ready  = r_rd_ready;
    assign q_valid   = r_q_valid;
    assign init_done = r_init_done;
    assign ctx_err   = r_ctx_err;
    assign A_Q       = w_q_word[34:22];
    assign B_Q       = w_q_word[21:15];
    assign C_Q       = w_q_word[14:7];
    assign N_Q       = w_q_word[6:0];

`ifdef CTX_FWD_STATS_EN
    logic [15:0] r_fwd_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_fwd_count <= '0;
        else if (w_collide && (r_fwd_count != 16'hFFFF))
            r_fwd_count <= r_fwd_count + 16'd1;
    end

    assign fwd_count = r_fwd_count;
    assign init_busy = ~r_init_done;
`endif

endmodule

// File: tb/tb_context_store.sv
// Directed, table-driven bench for context_store: sweep timing, read/write, forwarding and out-of-range handling.
module tb_context_store;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_valid;
    logic [8:0]        rd_ctx;
    logic              rd_ready;
    logic              q_valid;
    logic [12:0]       A_Q;
    logic signed [6:0] B_Q;
    logic signed [7:0] C_Q;
    logic [6:0]        N_Q;
    logic              wr_en;
    logic [8:0]        wr_ctx;
    logic [12:0]       A_Q_update;
    logic signed [6:0] B_Q_update;
    logic signed [7:0] C_Q_update;
    logic [6:0]        N_Q_update;
    logic              init_done;
    logic              ctx_err;
`ifdef CTX_FWD_STATS_EN
    logic [15:0]       fwd_count;
    logic              init_busy;
`endif

    always #5 clk = ~clk;

    context_store dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_ctx(rd_ctx), .rd_ready(rd_ready), .q_valid(q_valid),
        .A_Q(A_Q), .B_Q(B_Q), .C_Q(C_Q), .N_Q(N_Q),
        .wr_en(wr_en), .wr_ctx(wr_ctx),
        .A_Q_update(A_Q_update), .B_Q_update(B_Q_update),
        .C_Q_update(C_Q_update), .N_Q_update(N_Q_update),
        .init_done(init_done), .ctx_err(ctx_err)
`ifdef CTX_FWD_STATS_EN
        , .fwd_count(fwd_count), .init_busy(init_busy)
`endif
    );

    typedef struct {
        string       name;
        bit          rd;
        logic [8:0]  rctx;
        bit          wr;
        logic [8:0]  wctx;
        logic [34:0] wd;
        bit          eqv;
        logic [34:0] ed;
        bit          eerr;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [34:0] w(input int a, input int b, input int c, input int n);
        return {13'(a), 7'(b), 8'(c), 7'(n)};
    endfunction

    function automatic vec_t mk(input string nm, input bit rd, input int rc, input bit wr,
                                input int wc, input logic [34:0] wd, input bit eqv,
                                input logic [34:0] ed, input bit eerr);
        vec_t v;
        v.name = nm; v.rd = rd; v.rctx = 9'(rc); v.wr = wr; v.wctx = 9'(wc);
        v.wd = wd; v.eqv = eqv; v.ed = ed; v.eerr = eerr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input bit rd, input logic [8:0] rc, input bit wr, input logic [8:0] wc,
                         input logic [34:0] wd);
        rd_valid = rd; rd_ctx = rc; wr_en = wr; wr_ctx = wc;
        {A_Q_update, B_Q_update, C_Q_update, N_Q_update} = wd;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive(v.rd, v.rctx, v.wr, v.wctx, v.wd);
        @(posedge clk); #1;
        chk({v.name, "_qv_err"}, 64'({q_valid, ctx_err}), 64'({v.eqv, v.eerr}));
        if (v.eqv)
            chk({v.name, "_data"}, 64'({A_Q, B_Q, C_Q, N_Q}), 64'(v.ed));
        @(negedge clk);
        drive(1'b0, '0, 1'b0, '0, '0);
    endtask

    // Releases reset and counts edges until rd_ready rises; the sweep must take exactly 365.
    task automatic wait_init(input string nm);
        int n = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 1000; i++) begin
            @(posedge clk); #1;
            if (rd_ready) begin
                n = i;
                break;
            end
        end
        chk({nm, "_cycles"}, 64'(n), 64'd365);
        chk({nm, "_done"}, 64'(init_done), 64'd1);
    endtask

    task automatic seq_step(input string nm, input bit rd, input int rc, input bit wr, input int wc,
                            input logic [34:0] wd, input bit eqv, input logic [34:0] ed);
        @(negedge clk);
        drive(rd, 9'(rc), wr, 9'(wc), wd);
        @(posedge clk); #1;
        chk({nm, "_qv"}, 64'(q_valid), 64'(eqv));
        chk({nm, "_data"}, 64'({A_Q, B_Q, C_Q, N_Q}), 64'(ed));
    endtask

    logic [34:0] IW;

    initial begin
        IW  = w(4, 0, 0, 1);
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, '0, '0);

        vecs.push_back(mk("rd0",      1, 0,   0, 0,   '0,               1, IW,                  0));
        vecs.push_back(mk("rd200",    1, 200, 0, 0,   '0,               1, IW,                  0));
        vecs.push_back(mk("rd364",    1, 364, 0, 0,   '0,               1, IW,                  0));
        vecs.push_back(mk("wr17",     0, 0,   1, 17,  w(100, -5, -3, 12), 0, '0,                0));
        vecs.push_back(mk("rd17",     1, 17,  0, 0,   '0,               1, {13'd100, 7'h7B, 8'hFD, 7'd12}, 0));
        vecs.push_back(mk("coll42",   1, 42,  1, 42,  w(9, 2, 1, 3),    1, w(9, 2, 1, 3),       0));
        vecs.push_back(mk("rd42",     1, 42,  0, 0,   '0,               1, w(9, 2, 1, 3),       0));
        vecs.push_back(mk("rd400",    1, 400, 0, 0,   '0,               1, IW,                  1));
        vecs.push_back(mk("wr365",    0, 0,   1, 365, w(77, 1, 1, 1),   0, '0,                  1));
        vecs.push_back(mk("rd364b",   1, 364, 0, 0,   '0,               1, IW,                  0));
        vecs.push_back(mk("rd17wr18", 1, 17,  1, 18,  w(1, -1, -1, 2),  1, {13'd100, 7'h7B, 8'hFD, 7'd12}, 0));
        vecs.push_back(mk("rd18",     1, 18,  0, 0,   '0,               1, {13'd1, 7'h7F, 8'hFF, 7'd2}, 0));

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 64'({rd_ready, q_valid, init_done, ctx_err, A_Q, B_Q, C_Q, N_Q}), 64'd0);
        wait_init("init");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back pixels: ctx 5, 6, 5 with write-backs issued at each q_valid cycle.
        seq_step("b2b_r5",     1, 5, 0, 0, '0,                1, IW);
        seq_step("b2b_r6",     1, 6, 1, 5, w(20, 3, -2, 2),   1, IW);
        seq_step("b2b_r5b",    1, 5, 1, 6, w(30, -1, 4, 2),   1, w(20, 3, -2, 2));
        seq_step("b2b_hold",   0, 0, 1, 5, w(21, 2, -1, 3),   0, w(20, 3, -2, 2));
        seq_step("b2b_r5c",    1, 5, 0, 0, '0,                1, w(21, 2, -1, 3));
        seq_step("b2b_r6b",    1, 6, 0, 0, '0,                1, w(30, -1, 4, 2));
        @(negedge clk);
        drive(1'b0, '0, 1'b0, '0, '0);
`ifdef CTX_FWD_STATS_EN
        chk("fwd_count", 64'(fwd_count), 64'd1);
        chk("init_busy_run", 64'(init_busy), 64'd0);
`endif

        // Reset in the middle of the sweep restarts it from address 0.
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("mid_init_busy", 64'({rd_ready, init_done}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_init_reset", 64'({rd_ready, q_valid, init_done, A_Q, B_Q, C_Q, N_Q}), 64'd0);
        wait_init("reinit");
        run_vec(mk("re_rd17", 1, 17, 0, 0, '0, 1, IW, 0));
        run_vec(mk("re_rd42", 1, 42, 0, 0, '0, 1, IW, 0));
        run_vec(mk("re_rd5",  1, 5,  0, 0, '0, 1, IW, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/context_store.md
Name: context_store

Overview:
- Per-context state memory for the LOCO-I regular-mode path. Holds A/B/C/N for every context.
- On request it presents one context's stored values to context_update, and it writes back the updated values that context_update returns.
- Sits between the context-index (Q) computation stage and context_update.
- Clears all contexts at reset and forwards pending write-backs so that back-to-back pixels in the same context always see current state.

Parameters:
- NUM_CTX, 365, number of contexts; legal index range is 0..NUM_CTX-1.
- CTX_W, 9, width of the context index.
- A_INIT, 4, reset value of A (8-bit samples: max(2,(255+32)>>6) = 4).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rd_valid  in  1  read request
- rd_ctx  in  CTX_W  context index to read
- rd_ready  out  1  request accepted when rd_valid && rd_ready
- q_valid  out  1  read data valid, one-cycle pulse
- A_Q  out  13  stored A
- B_Q  out  7  stored B, signed
- C_Q  out  8  stored C, signed
- N_Q  out  7  stored N
- wr_en  in  1  write-back strobe
- wr_ctx  in  CTX_W  context index to write
- A_Q_update  in  13  new A
- B_Q_update  in  7  new B, signed
- C_Q_update  in  8  new C, signed
- N_Q_update  in  7  new N
- init_done  out  1  high once the clear sweep is complete
- ctx_err  out  1  one-cycle pulse on an out-of-range read or write index

Behaviour:
- Storage: NUM_CTX words of 35 bits, packed {A,B,C,N}. Synchronous single-port-read / single-port-write RAM; inferable as block RAM.
- Reset values: rd_ready=0, q_valid=0, A_Q=0, B_Q=0, C_Q=0, N_Q=0, init_done=0, ctx_err=0. The init counter is cleared to 0.
- States:
  - INIT: each cycle writes {A_INIT,0,0,1} to address cnt, then cnt++. After writing NUM_CTX-1, go to RUN on the next edge and set init_done=1. INIT lasts exactly NUM_CTX cycles.
  - In INIT, rd_ready=0 and wr_en is ignored.
  - RUN: rd_ready=1 every cycle. Stays in RUN until rst.
- rst asserted in any state, including mid-INIT: return to INIT with cnt=0 and outputs at reset values. The sweep restarts from address 0.
- Read latency: request accepted at edge t, so q_valid=1 and data valid in the cycle after edge t. A_Q..N_Q hold their value until the next accepted read. There is no output backpressure.
- Write: in RUN with wr_en=1, the word at wr_ctx is updated at that edge.
- Forwarding, same-cycle collision: a read is accepted and wr_en=1 with wr_ctx==rd_ctx in the same cycle. Output data is the write data (A/B/C/N_Q_update), not the old RAM word.
- Forwarding, in-flight write:
  - If wr_en=1 in the cycle q_valid=1 and wr_ctx equals the index of the data being presented, the RAM write is performed as normal.
  - Outputs are not altered; the data presented is already committed.
- Simultaneous read and write to different contexts: both take effect; no stall.
- Out-of-range index (>= NUM_CTX):
  - A read returns {A_INIT,0,0,1} with q_valid=1.
  - A write is dropped.
  - ctx_err pulses one cycle after the offending request.
- No arithmetic is performed on stored fields. B and C are stored and returned bit-exact as two's complement.

Optional Feature:
- Macro CTX_FWD_STATS_EN.
- Defined:
  - Adds output fwd_count [15:0], reset to 0.
  - Increments by 1 on each same-cycle forwarding event and saturates at 16'hFFFF.
  - Adds output init_busy, equal to ~init_done.
- Undefined: neither port exists and no counter logic is generated. All other behaviour is identical.

Test Plan:
- Reset, then idle: rd_ready=0 for exactly 365 cycles after rst falls, then init_done=1. Reading ctx 0, 200 and 364 returns A=4, B=0, C=0, N=1.
- Write ctx 17 with {A=100,B=-5,C=-3,N=12}, then read ctx 17 two cycles later. The read returns A=100, B=7'h7B, C=8'hFD, N=12, with q_valid one cycle after acceptance.
- Same-cycle collision: read ctx 42 while writing ctx 42 with {A=9,B=2,C=1,N=3}. Output is 9/2/1/3. A following read of ctx 42 also returns 9/2/1/3.
- Back-to-back reads of ctx 5, 6 and 5, each with the prior pixel's write-back issued at its q_valid cycle. The third read sees ctx 5's updated value. With CTX_FWD_STATS_EN defined, fwd_count matches the number of same-cycle collisions.
- Out-of-range: read ctx 400 returns {4,0,0,1} and ctx_err pulses. A write to ctx 365 is dropped, and ctx 364 is unchanged.
- Assert rst at cycle 100 of INIT: the sweep restarts, and init_done rises 365 cycles after rst deasserts. Data written before the reset reads back as initial values.
